// File: rtl/stone_plotter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stone_plotter_pkg
//  Description : Shared encodings for the board-cell plotter: drawing modes,
//                default palette, FSM states and colour selectors.
//  Revision    : 1.0 - initial release
// ============================================================================
package stone_plotter_pkg;

    // Drawing modes as presented on the request bus
    typedef enum logic [1:0] {
        MODE_BLACK  = 2'b00,
        MODE_WHITE  = 2'b01,
        MODE_ERASE  = 2'b10,
        MODE_CURSOR = 2'b11
    } mode_e;

    // Default palette (3-bit RGB as accepted by vga_adapter)
    localparam logic [2:0] C_BLACK_COL  = 3'b000;
    localparam logic [2:0] C_WHITE_COL  = 3'b111;
    localparam logic [2:0] C_BG_COL     = 3'b110;
    localparam logic [2:0] C_GRID_COL   = 3'b000;
    localparam logic [2:0] C_CURSOR_COL = 3'b100;

    // Plotter sequencing
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Which palette entry a pixel uses; resolved to a colour in the top
    typedef enum logic [2:0] {
        SEL_BLACK  = 3'd0,
        SEL_WHITE  = 3'd1,
        SEL_BG     = 3'd2,
        SEL_GRID   = 3'd3,
        SEL_CURSOR = 3'd4
    } colour_sel_e;

endpackage
`default_nettype wire

// File: rtl/stone_plotter_if.sv
`default_nettype none
// ============================================================================
//  Module      : stone_plotter_if
//  Description : Request/status handshake from the game FSM plus the pixel
//                write port toward vga_adapter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface stone_plotter_if #(
    parameter int BOARD_DIM = 15
);
    localparam int RC_W = (BOARD_DIM > 1) ? $clog2(BOARD_DIM) : 1;

    logic            req;
    logic [RC_W-1:0] row;
    logic [RC_W-1:0] col;
    logic [1:0]      mode;
    logic            busy;
    logic            done;
    logic            err;
    logic [7:0]      x;
    logic [6:0]      y;
    logic [2:0]      colour;
    logic            plot;

    // Requester side (game FSM / testbench)
    modport master (
        output req, row, col, mode,
        input  busy, done, err, x, y, colour, plot
    );

    // Plotter side
    modport slave (
        input  req, row, col, mode,
        output busy, done, err, x, y, colour, plot
    );
endinterface
`default_nettype wire

// File: rtl/stone_plotter_mask.sv
`default_nettype none
// ============================================================================
//  Module      : stone_mask
//  Description : Per-pixel shape logic. Maps the offset (dx,dy) inside the
//                stone square and the drawing mode to a plot enable and a
//                palette selector. Optional round stones: ROUND_STONE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module stone_mask
    import stone_plotter_pkg::*;
#(
    parameter int CELL_PX  = 8,
    parameter int STONE_PX = 6
) (
    input  wire logic [8:0]  i_dx,
    input  wire logic [8:0]  i_dy,
    input  wire mode_e       i_mode,
    output logic             o_plot_en,
    output colour_sel_e      o_colour_sel
);
    localparam logic [8:0] OFF  = 9'((CELL_PX - STONE_PX) / 2);
    localparam logic [8:0] MID  = 9'(CELL_PX / 2);
    localparam logic [8:0] LAST = 9'(STONE_PX - 1);

    logic w_on_grid;
    logic w_on_edge;
    logic w_corner_cut;

    // Grid lines run through the cell centre; the perimeter is the cursor box
    assign w_on_grid = ((i_dx + OFF) == MID) || ((i_dy + OFF) == MID);
    assign w_on_edge = (i_dx == 9'd0) || (i_dx == LAST) ||
                       (i_dy == 9'd0) || (i_dy == LAST);

`ifdef ROUND_STONE_EN
    localparam logic [8:0] QUARTER = 9'(STONE_PX / 4);
    logic [8:0] w_min_x;
    logic [8:0] w_min_y;
    // Manhattan distance to the nearest corner decides which pixels are cut
    assign w_min_x      = (i_dx < (LAST - i_dx)) ? i_dx : (LAST - i_dx);
    assign w_min_y      = (i_dy < (LAST - i_dy)) ? i_dy : (LAST - i_dy);
    assign w_corner_cut = (w_min_x + w_min_y) < QUARTER;
`else
    assign w_corner_cut = 1'b0;
`endif

    // Mode-dependent enable and palette choice
    always_comb begin
        o_plot_en    = 1'b1;
        o_colour_sel = SEL_BLACK;
        case (i_mode)
            MODE_BLACK: begin
                o_colour_sel = SEL_BLACK;
                o_plot_en    = ~w_corner_cut;
            end
            MODE_WHITE: begin
                o_colour_sel = SEL_WHITE;
                o_plot_en    = ~w_corner_cut;
            end
            MODE_ERASE: begin
                o_colour_sel = w_on_grid ? SEL_GRID : SEL_BG;
            end
            MODE_CURSOR: begin
                o_colour_sel = SEL_CURSOR;
                o_plot_en    = w_on_edge;
            end
            default: begin
                o_colour_sel = SEL_BG;
            end
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/stone_plotter.sv
`default_nettype none
// ============================================================================
//  Module      : stone_plotter
//  Description : Draws one board cell (black, white, erase, cursor) onto the
//                160x120 vga_adapter plot port, one pixel per clock.
//                Optional feature macro: ROUND_STONE_EN (round stones).
//  Revision    : 1.0 - initial release
// ============================================================================
module stone_plotter
    import stone_plotter_pkg::*;
#(
    parameter int         BOARD_DIM  = 15,
    parameter int         CELL_PX    = 8,
    parameter int         STONE_PX   = 6,
    parameter int         ORIGIN_X   = 20,
    parameter int         ORIGIN_Y   = 0,
    parameter logic [2:0] BLACK_COL  = C_BLACK_COL,
    parameter logic [2:0] WHITE_COL  = C_WHITE_COL,
    parameter logic [2:0] BG_COL     = C_BG_COL,
    parameter logic [2:0] GRID_COL   = C_GRID_COL,
    parameter logic [2:0] CURSOR_COL = C_CURSOR_COL
) (
    input  wire logic        CLOCK_50,
    input  wire logic        resetn,
    stone_plotter_if.slave   bus
);
    localparam logic [8:0] OFF  = 9'((CELL_PX - STONE_PX) / 2);
    localparam logic [8:0] LAST = 9'(STONE_PX - 1);

    state_e      r_state;
    mode_e       r_mode;
    logic [8:0]  r_bx;
    logic [8:0]  r_by;
    logic [8:0]  r_dx;
    logic [8:0]  r_dy;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic [7:0]  r_x;
    logic [6:0]  r_y;
    logic [2:0]  r_colour;
    logic        r_plot;

    logic        w_idle;
    logic        w_in_range;
    logic        w_last_dx;
    logic        w_last_px;
    logic [8:0]  w_ndx;
    logic [8:0]  w_ndy;
    logic [8:0]  w_new_bx;
    logic [8:0]  w_new_by;
    logic [8:0]  w_base_x;
    logic [8:0]  w_base_y;
    logic [7:0]  w_px_x;
    logic [6:0]  w_px_y;
    mode_e       w_mask_mode;
    logic        w_plot_en;
    colour_sel_e w_sel;
    logic [2:0]  w_colour;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_in_range = (9'(bus.row) < 9'(BOARD_DIM)) && (9'(bus.col) < 9'(BOARD_DIM));

    // Base corner of the stone square for an incoming request
    assign w_new_bx = 9'(ORIGIN_X) + 9'(bus.col) * 9'(CELL_PX) + OFF;
    assign w_new_by = 9'(ORIGIN_Y) + 9'(bus.row) * 9'(CELL_PX) + OFF;

    // Raster step: dx inner, dy outer; in IDLE the next pixel is (0,0)
    assign w_last_dx = (r_dx == LAST);
    assign w_last_px = w_last_dx && (r_dy == LAST);
    assign w_ndx     = w_idle ? 9'd0 : (w_last_dx ? 9'd0 : r_dx + 9'd1);
    assign w_ndy     = w_idle ? 9'd0 : (w_last_dx ? r_dy + 9'd1 : r_dy);

    // The first pixel is produced on the accepting edge, before inputs are latched
    assign w_base_x    = w_idle ? w_new_bx : r_bx;
    assign w_base_y    = w_idle ? w_new_by : r_by;
    assign w_mask_mode = w_idle ? mode_e'(bus.mode) : r_mode;
    assign w_px_x      = 8'(w_base_x + w_ndx);
    assign w_px_y      = 7'(w_base_y + w_ndy);

    stone_mask #(
        .CELL_PX  (CELL_PX),
        .STONE_PX (STONE_PX)
    ) u_mask (
        .i_dx         (w_ndx),
        .i_dy         (w_ndy),
        .i_mode       (w_mask_mode),
        .o_plot_en    (w_plot_en),
        .o_colour_sel (w_sel)
    );

    // Resolve the palette selector to the configured colour
    always_comb begin
        w_colour = BG_COL;
        case (w_sel)
            SEL_BLACK:  w_colour = BLACK_COL;
            SEL_WHITE:  w_colour = WHITE_COL;
            SEL_BG:     w_colour = BG_COL;
            SEL_GRID:   w_colour = GRID_COL;
            SEL_CURSOR: w_colour = CURSOR_COL;
            default:    w_colour = BG_COL;
        endcase
    end

    // Sequencer: accept, raster the square, pulse done; all outputs registered
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            r_state  <= ST_IDLE;
            r_mode   <= MODE_BLACK;
            r_bx     <= 9'd0;
            r_by     <= 9'd0;
            r_dx     <= 9'd0;
            r_dy     <= 9'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_x      <= 8'd0;
            r_y      <= 7'd0;
            r_colour <= 3'd0;
            r_plot   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_plot <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.req) begin
                        r_mode <= mode_e'(bus.mode);
                        r_bx   <= w_new_bx;
                        r_by   <= w_new_by;
                        if (w_in_range) begin
                            r_state  <= ST_DRAW;
                            r_busy   <= 1'b1;
                            r_dx     <= w_ndx;
                            r_dy     <= w_ndy;
                            r_x      <= w_px_x;
                            r_y      <= w_px_y;
                            r_colour <= w_colour;
                            r_plot   <= w_plot_en;
                        end else begin
                            // Bad cell: report immediately, draw nothing
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end
                    end
                end
                ST_DRAW: begin
                    if (w_last_px) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_dx     <= w_ndx;
                        r_dy     <= w_ndy;
                        r_x      <= w_px_x;
                        r_y      <= w_px_y;
                        r_colour <= w_colour;
                        r_plot   <= w_plot_en;
                    end
                end
                ST_DONE: begin
                    // Requests arriving here are dropped, not queued
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.err    = r_err;
    assign bus.x      = r_x;
    assign bus.y      = r_y;
    assign bus.colour = r_colour;
    assign bus.plot   = r_plot;
endmodule
`default_nettype wire

// File: tb/tb_stone_plotter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stone_plotter
//  Description : Directed, table-driven bench for stone_plotter at default
//                geometry, plus hand sequences for interlock and reset abort.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stone_plotter;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    stone_plotter_if #(.BOARD_DIM(15)) bus();

    stone_plotter dut (
        .CLOCK_50 (clk),
        .resetn   (rstn),
        .bus      (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        int row;
        int col;
        int mode;
        int bx;
        int by;
        int n_plot;
        int done_cyc;
        int err;
        int n_c0;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Independent reference for one pixel of the 6x6 square (offset 1, centre 4)
    task automatic model(input int mode, input int dx, input int dy,
                         output int pl, output int colour);
        int mx, my;
        mx = (dx < 5 - dx) ? dx : 5 - dx;
        my = (dy < 5 - dy) ? dy : 5 - dy;
        pl = 1;
        colour = 0;
        case (mode)
            0: colour = 0;
            1: colour = 7;
            2: colour = ((dx + 1 == 4) || (dy + 1 == 4)) ? 0 : 6;
            default: begin
                colour = 4;
                pl = (dx == 0 || dx == 5 || dy == 0 || dy == 5) ? 1 : 0;
            end
        endcase
`ifdef ROUND_STONE_EN
        if (mode < 2 && (mx + my) < 1) pl = 0;
`else
        if (mx + my < 0) pl = 0;
`endif
    endtask

    // Issue one request and follow it through to done
    task automatic run_vec(input vec_t v, input string tag);
        int cyc, nplot, nc0, pl, colour, done_cyc;
        bus.row  = 4'(v.row);
        bus.col  = 4'(v.col);
        bus.mode = 2'(v.mode);
        bus.req  = 1'b1;
        step();
        bus.req  = 1'b0;
        cyc = 1; nplot = 0; nc0 = 0; done_cyc = -1;
        while (cyc <= 60) begin
            if (bus.done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            if (bus.plot === 1'b1) begin
                nplot++;
                if (bus.colour == 3'b000) nc0++;
            end
            if (v.err == 0 && cyc <= 36) begin
                model(v.mode, (cyc - 1) % 6, (cyc - 1) / 6, pl, colour);
                chk({tag, " plot"}, 32'(bus.plot), 32'(pl));
                if (pl == 1) begin
                    chk({tag, " x"}, 32'(bus.x), 32'(v.bx + (cyc - 1) % 6));
                    chk({tag, " y"}, 32'(bus.y), 32'(v.by + (cyc - 1) / 6));
                    chk({tag, " colour"}, 32'(bus.colour), 32'(colour));
                end
                chk({tag, " busy"}, 32'(bus.busy), 32'd1);
            end
            step();
            cyc++;
        end
        chk({tag, " done cycle"}, 32'(done_cyc), 32'(v.done_cyc));
        chk({tag, " err"}, 32'(bus.err), 32'(v.err));
        chk({tag, " busy at done"}, 32'(bus.busy), 32'd0);
        chk({tag, " plot at done"}, 32'(bus.plot), 32'd0);
        chk({tag, " plot count"}, 32'(nplot), 32'(v.n_plot));
        chk({tag, " colour-000 count"}, 32'(nc0), 32'(v.n_c0));
        step();
        chk({tag, " done pulse width"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int ndone, nwhite;
        int nround = 36;
`ifdef ROUND_STONE_EN
        nround = 32;
`endif
        //           row col mode  bx   by  plots  done err c0
        vecs[0] = '{0,  0,  0,   21,  1,  nround, 37, 0, nround};
        vecs[1] = '{3,  4,  1,   53,  25, nround, 37, 0, 0};
        vecs[2] = '{7,  7,  2,   77,  57, 36,     37, 0, 11};
        vecs[3] = '{14, 14, 3,   133, 113, 20,    37, 0, 0};
        vecs[4] = '{15, 0,  0,   0,   0,  0,      1,  1, 0};
        vecs[5] = '{2,  15, 1,   0,   0,  0,      1,  1, 0};
        vecs[6] = '{0,  14, 2,   133, 1,  36,     37, 0, 11};

        rstn = 1'b0;
        bus.req = 1'b0; bus.row = '0; bus.col = '0; bus.mode = '0;
        step(); step(); step();
        chk("reset busy",   32'(bus.busy),   32'd0);
        chk("reset done",   32'(bus.done),   32'd0);
        chk("reset err",    32'(bus.err),    32'd0);
        chk("reset plot",   32'(bus.plot),   32'd0);
        chk("reset x",      32'(bus.x),      32'd0);
        chk("reset y",      32'(bus.y),      32'd0);
        chk("reset colour", 32'(bus.colour), 32'd0);
        rstn = 1'b1;
        step();

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            step();
        end

        // Busy interlock: white request held across an active black draw
        bus.row = 4'd0; bus.col = 4'd0; bus.mode = 2'b00; bus.req = 1'b1;
        step();
        bus.req = 1'b0;
        ndone = 0; nwhite = 0;
        for (int k = 1; k <= 37; k++) begin
            if (k == 5) begin
                bus.row = 4'd3; bus.col = 4'd4; bus.mode = 2'b01; bus.req = 1'b1;
            end
            if (bus.done === 1'b1) begin
                ndone++;
                chk("interlock done cycle", 32'(k), 32'd37);
            end
            if (bus.plot === 1'b1 && bus.colour == 3'b111) nwhite++;
            step();
        end
        // Cycle after done: previous req (held through DONE) must have been dropped
        chk("interlock done count", 32'(ndone), 32'd1);
        chk("interlock white pixels", 32'(nwhite), 32'd0);
        chk("interlock idle busy", 32'(bus.busy), 32'd0);
        chk("interlock idle plot", 32'(bus.plot), 32'd0);
        bus.row = 4'd1; bus.col = 4'd1; bus.mode = 2'b11; bus.req = 1'b1;
        step();
        bus.req = 1'b0;
        chk("b2b first plot",   32'(bus.plot),   32'd1);
        chk("b2b first x",      32'(bus.x),      32'd29);
        chk("b2b first y",      32'(bus.y),      32'd9);
        chk("b2b first colour", 32'(bus.colour), 32'd4);
        chk("b2b busy",         32'(bus.busy),   32'd1);
        ndone = 0;
        for (int k = 2; k <= 40; k++) begin
            step();
            if (bus.done === 1'b1) begin
                ndone++;
                chk("b2b done cycle", 32'(k), 32'd37);
            end
        end
        chk("b2b done count", 32'(ndone), 32'd1);

        // Reset mid-draw aborts silently
        bus.row = 4'd2; bus.col = 4'd2; bus.mode = 2'b00; bus.req = 1'b1;
        step();
        bus.req = 1'b0;
        for (int k = 2; k <= 10; k++) step();
        rstn = 1'b0;
        step();
        chk("abort plot", 32'(bus.plot), 32'd0);
        chk("abort busy", 32'(bus.busy), 32'd0);
        chk("abort done", 32'(bus.done), 32'd0);
        rstn = 1'b1;
        ndone = 0;
        for (int k = 0; k < 45; k++) begin
            step();
            if (bus.done === 1'b1 || bus.plot === 1'b1) ndone++;
        end
        chk("abort no activity", 32'(ndone), 32'd0);
        run_vec(vecs[0], "post-abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
